// File: rtl/issue_window.sv
// In-order issue window: circular buffer tracking dispatch, issue, writeback and commit.
// Each entry's flags and operands live in an issue_window_entry instance; trans_id = buffer index.

module issue_window_entry #(
  parameter int unsigned DATA_W = 79
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              alloc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              kill_unissued_i,
  input  logic              issue_i,
  input  logic              wb_i,
  input  logic              retire_i,
  output logic              valid_o,
  output logic              issued_o,
  output logic              done_o,
  output logic [DATA_W-1:0] data_o
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o  <= 1'b0;
      issued_o <= 1'b0;
      done_o   <= 1'b0;
      data_o   <= '0;
    end else if (flush_i) begin
      valid_o  <= 1'b0;
      issued_o <= 1'b0;
      done_o   <= 1'b0;
    end else if (alloc_i) begin
      valid_o  <= 1'b1;
      issued_o <= 1'b0;
      done_o   <= 1'b0;
      data_o   <= data_i;
    end else if (retire_i) begin
      valid_o <= 1'b0;
    end else begin
      if (kill_unissued_i && !issued_o) valid_o <= 1'b0;
      if (issue_i) issued_o <= 1'b1;
      // Writebacks only land on live, issued entries; stale or duplicate ones are dropped.
      if (wb_i && valid_o && issued_o) done_o <= 1'b1;
    end
  end
endmodule

module issue_window #(
  parameter  int unsigned NR_ENTRIES      = 8,
  parameter  int unsigned NR_WB_PORTS     = 4,
  parameter  int unsigned NR_COMMIT_PORTS = 2,
  parameter  int unsigned PAYLOAD_W       = 64,
  localparam int unsigned IDX_W           = $clog2(NR_ENTRIES)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic                                         flush_unissued_i,
  input  logic                                         dec_valid_i,
  output logic                                         dec_ready_o,
  input  logic [4:0]                                   dec_rd_i,
  input  logic [4:0]                                   dec_rs1_i,
  input  logic [4:0]                                   dec_rs2_i,
  input  logic [PAYLOAD_W-1:0]                         dec_payload_i,
  output logic                                         issue_valid_o,
  input  logic                                         issue_ready_i,
  output logic [IDX_W-1:0]                             issue_trans_id_o,
  output logic [PAYLOAD_W-1:0]                         issue_payload_o,
  input  logic [NR_WB_PORTS-1:0]                       wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][IDX_W-1:0]            wb_trans_id_i,
  output logic [NR_COMMIT_PORTS-1:0]                   commit_valid_o,
  output logic [NR_COMMIT_PORTS-1:0][IDX_W-1:0]        commit_trans_id_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]              commit_rd_o,
  output logic [NR_COMMIT_PORTS-1:0][PAYLOAD_W-1:0]    commit_payload_o,
  input  logic [NR_COMMIT_PORTS-1:0]                   commit_ack_i,
  output logic                                         full_o,
  output logic                                         stall_issue_o
);
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   cnt_t;
  typedef struct packed {
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [PAYLOAD_W-1:0] payload;
  } ent_t;

  localparam cnt_t FULL_CNT = cnt_t'(NR_ENTRIES);

  idx_t head_q, iss_q, tail_q;
  cnt_t count_q, retired, n_issued;
  ent_t ent_d, cur;
  ent_t ent_q [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] valid_q, issued_q, done_q;
  logic [NR_ENTRIES-1:0] alloc_e, issue_e, wb_e, retire_e;
  logic [NR_COMMIT_PORTS-1:0] ack_eff;
  logic dispatch, candidate, clobber, fire, kill;

  assign dec_ready_o = (count_q < FULL_CNT);
  assign full_o      = (count_q == FULL_CNT);
  assign kill        = flush_unissued_i & ~flush_i;
  assign dispatch    = dec_valid_i & dec_ready_o & ~flush_i & ~flush_unissued_i;
  assign ent_d       = '{rd: dec_rd_i, rs1: dec_rs1_i, rs2: dec_rs2_i, payload: dec_payload_i};

  // Entries in [head, iss) are exactly the live issued ones, so the clobber scan needs no range math.
  always_comb begin
    cur     = ent_q[iss_q];
    clobber = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (valid_q[i] && issued_q[i] && !done_q[i] && ent_q[i].rd != 5'd0 &&
          (ent_q[i].rd == cur.rs1 || ent_q[i].rd == cur.rs2))
        clobber = 1'b1;
    end
  end

  assign candidate        = valid_q[iss_q] & ~issued_q[iss_q];
  assign issue_valid_o    = candidate & ~clobber & ~flush_i & ~flush_unissued_i;
  assign stall_issue_o    = candidate & clobber;
  assign fire             = issue_valid_o & issue_ready_i;
  assign issue_trans_id_o = iss_q;
  assign issue_payload_o  = cur.payload;

  // Commit port k needs every entry from head up to head+k done.
  always_comb begin
    logic ok;
    idx_t idx;
    ok = 1'b1;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      idx = head_q + idx_t'(k);
      ok  = ok & valid_q[idx] & done_q[idx];
      commit_valid_o[k]    = ok & (count_q > cnt_t'(k)) & ~flush_i;
      commit_trans_id_o[k] = idx;
      commit_rd_o[k]       = ent_q[idx].rd;
      commit_payload_o[k]  = ent_q[idx].payload;
    end
  end

  assign ack_eff = commit_ack_i & commit_valid_o;

  always_comb begin
    retired  = '0;
    n_issued = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++)
      if (ack_eff[k]) retired = retired + cnt_t'(1);
    for (int i = 0; i < NR_ENTRIES; i++)
      if (valid_q[i] && issued_q[i]) n_issued = n_issued + cnt_t'(1);
  end

  always_comb begin
    idx_t off;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      off         = idx_t'(i) - head_q;
      retire_e[i] = ({1'b0, off} < retired);
      alloc_e[i]  = dispatch & (tail_q == idx_t'(i));
      issue_e[i]  = fire & (iss_q == idx_t'(i));
      wb_e[i]     = 1'b0;
      for (int p = 0; p < NR_WB_PORTS; p++)
        if (wb_valid_i[p] && wb_trans_id_i[p] == idx_t'(i)) wb_e[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_ent
    issue_window_entry #(.DATA_W($bits(ent_t))) u_ent (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .alloc_i         (alloc_e[g]),
      .data_i          (ent_d),
      .kill_unissued_i (kill),
      .issue_i         (issue_e[g]),
      .wb_i            (wb_e[g]),
      .retire_i        (retire_e[g]),
      .valid_o         (valid_q[g]),
      .issued_o        (issued_q[g]),
      .done_o          (done_q[g]),
      .data_o          (ent_q[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      iss_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      iss_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_q + retired[IDX_W-1:0];
      if (fire) iss_q <= iss_q + idx_t'(1);
      if (flush_unissued_i) begin
        tail_q  <= iss_q;
        count_q <= n_issued - retired;
      end else begin
        if (dispatch) tail_q <= tail_q + idx_t'(1);
        count_q <= count_q + cnt_t'(dispatch) - retired;
      end
    end
  end

  // Retire strobes must form a prefix of the valid commit ports.
  assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i)
    ((commit_ack_i & ~commit_valid_o) == '0) &&
    ((commit_ack_i & (commit_ack_i + NR_COMMIT_PORTS'(1))) == '0));

endmodule

// File: tb/tb_issue_window.sv
// Directed bench for issue_window: dispatch/issue/RAW stall/writeback/commit/flush scenarios.

module tb_issue_window;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i, flush_unissued_i;
  logic        dec_valid_i, dec_ready_o;
  logic [4:0]  dec_rd_i, dec_rs1_i, dec_rs2_i;
  logic [63:0] dec_payload_i;
  logic        issue_valid_o, issue_ready_i;
  logic [2:0]  issue_trans_id_o;
  logic [63:0] issue_payload_o;
  logic [3:0]  wb_valid_i;
  logic [11:0] wb_trans_id_i;
  logic [1:0]  commit_valid_o;
  logic [5:0]  commit_trans_id_o;
  logic [9:0]  commit_rd_o;
  logic [127:0] commit_payload_o;
  logic [1:0]  commit_ack_i;
  logic        full_o, stall_issue_o;

  int nchk = 0;
  int nerr = 0;

  issue_window dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .flush_i           (flush_i),
    .flush_unissued_i  (flush_unissued_i),
    .dec_valid_i       (dec_valid_i),
    .dec_ready_o       (dec_ready_o),
    .dec_rd_i          (dec_rd_i),
    .dec_rs1_i         (dec_rs1_i),
    .dec_rs2_i         (dec_rs2_i),
    .dec_payload_i     (dec_payload_i),
    .issue_valid_o     (issue_valid_o),
    .issue_ready_i     (issue_ready_i),
    .issue_trans_id_o  (issue_trans_id_o),
    .issue_payload_o   (issue_payload_o),
    .wb_valid_i        (wb_valid_i),
    .wb_trans_id_i     (wb_trans_id_i),
    .commit_valid_o    (commit_valid_o),
    .commit_trans_id_o (commit_trans_id_o),
    .commit_rd_o       (commit_rd_o),
    .commit_payload_o  (commit_payload_o),
    .commit_ack_i      (commit_ack_i),
    .full_o            (full_o),
    .stall_issue_o     (stall_issue_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic disp(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [63:0] pl);
    dec_valid_i   = v;
    dec_rd_i      = rd;
    dec_rs1_i     = rs1;
    dec_rs2_i     = 5'd0;
    dec_payload_i = pl;
  endtask

  initial begin
    rst_ni = 1'b0;
    flush_i = 1'b0; flush_unissued_i = 1'b0;
    disp(1'b0, 5'd0, 5'd0, 64'd0);
    issue_ready_i = 1'b0; wb_valid_i = '0; wb_trans_id_i = '0; commit_ack_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", dec_ready_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_iv", issue_valid_o, 0);
    chk("rst_cv", commit_valid_o, 0);
    chk("rst_stall", stall_issue_o, 0);
    rst_ni = 1'b1;
    cyc();

    // 8 independent instructions, issued back to back
    issue_ready_i = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      disp(i < 8, 5'(i + 1), 5'd0, 64'h100 + 64'(i));
      #1;
      if (i == 0) chk("t1_iv_first", issue_valid_o, 0);
      else begin
        chk("t1_iv", issue_valid_o, 1);
        chk("t1_id", issue_trans_id_o, 64'(i - 1));
        chk("t1_pl", issue_payload_o, 64'h100 + 64'(i - 1));
      end
      if (i == 8) begin
        chk("t1_full", full_o, 1);
        chk("t1_ready", dec_ready_o, 0);
      end
      cyc();
    end
    disp(1'b0, 5'd0, 5'd0, 64'd0);
    wb_valid_i = 4'hF; wb_trans_id_i = {3'd3, 3'd2, 3'd1, 3'd0};
    #1;
    chk("t1_iv_empty", issue_valid_o, 0);
    chk("t1_cv_pre", commit_valid_o, 0);
    cyc();
    wb_trans_id_i = {3'd7, 3'd6, 3'd5, 3'd4};
    for (int k = 0; k < 4; k++) begin
      commit_ack_i = 2'b11;
      #1;
      chk("t1_cv", commit_valid_o, 2'b11);
      chk("t1_ctid", commit_trans_id_o, {3'(2 * k + 1), 3'(2 * k)});
      chk("t1_crd", commit_rd_o, {5'(2 * k + 2), 5'(2 * k + 1)});
      cyc();
      wb_valid_i = '0;
    end
    commit_ack_i = '0;
    #1;
    chk("t1_cv_end", commit_valid_o, 0);
    chk("t1_count_end", dut.count_q, 0);
    chk("t1_ready_end", dec_ready_o, 1);
    cyc();

    // RAW clobber: producer rd=5 (idx0), consumer rs1=5 (idx1)
    disp(1'b1, 5'd5, 5'd0, 64'hA0);
    #1; chk("t2_iv0", issue_valid_o, 0); cyc();
    disp(1'b1, 5'd7, 5'd5, 64'hA1);
    #1; chk("t2_iv_prod", issue_valid_o, 1); chk("t2_id_prod", issue_trans_id_o, 0); cyc();
    disp(1'b0, 5'd0, 5'd0, 64'd0);
    for (int j = 0; j < 3; j++) begin
      if (j == 2) begin wb_valid_i = 4'b0001; wb_trans_id_i = '0; end
      #1;
      chk("t2_stall", stall_issue_o, 1);
      chk("t2_iv_blk", issue_valid_o, 0);
      cyc();
    end
    wb_valid_i = '0; commit_ack_i = 2'b01;
    #1;
    chk("t2_stall_off", stall_issue_o, 0);
    chk("t2_iv_cons", issue_valid_o, 1);
    chk("t2_id_cons", issue_trans_id_o, 1);
    chk("t2_cv", commit_valid_o, 2'b01);
    cyc();
    commit_ack_i = '0; wb_valid_i = 4'b0001; wb_trans_id_i = 12'd1;
    #1; chk("t2_cv_wait", commit_valid_o, 0); cyc();
    wb_valid_i = '0; commit_ack_i = 2'b01;
    #1; chk("t2_cv2", commit_valid_o, 2'b01); chk("t2_ctid2", commit_trans_id_o[2:0], 1); cyc();
    commit_ack_i = '0;

    // rd=0 producer (idx2) never blocks an rs1=0 consumer (idx3)
    disp(1'b1, 5'd0, 5'd0, 64'hB0);
    #1; cyc();
    disp(1'b1, 5'd3, 5'd0, 64'hB1);
    #1; chk("t3_iv_p", issue_valid_o, 1); chk("t3_id_p", issue_trans_id_o, 2); cyc();
    disp(1'b0, 5'd0, 5'd0, 64'd0);
    #1;
    chk("t3_iv_c", issue_valid_o, 1);
    chk("t3_id_c", issue_trans_id_o, 3);
    chk("t3_stall", stall_issue_o, 0);
    cyc();

    // two-port writeback, dual commit
    wb_valid_i = 4'b0011; wb_trans_id_i = {3'd0, 3'd0, 3'd2, 3'd3};
    #1; chk("t4_cv_pre", commit_valid_o, 0); cyc();
    wb_valid_i = '0; commit_ack_i = 2'b11;
    #1; chk("t4_cv", commit_valid_o, 2'b11); chk("t4_ctid", commit_trans_id_o, {3'd3, 3'd2}); cyc();
    commit_ack_i = '0;
    #1; chk("t4_count", dut.count_q, 0); chk("t4_cv_post", commit_valid_o, 0);

    // fill from index 4 so trans_ids wrap past 7
    for (int i = 0; i <= 8; i++) begin
      disp(i < 8, 5'(i + 1), 5'd0, 64'hC0 + 64'(i));
      #1;
      if (i > 0) chk("t5_wrap_id", issue_trans_id_o, 64'((4 + i - 1) % 8));
      if (i == 8) chk("t5_full", full_o, 1);
      cyc();
    end
    disp(1'b0, 5'd0, 5'd0, 64'd0);
    wb_valid_i = 4'b0001; wb_trans_id_i = 12'd4;
    #1; chk("t5_iv_none", issue_valid_o, 0); cyc();
    wb_valid_i = '0; commit_ack_i = 2'b01;
    disp(1'b1, 5'd9, 5'd0, 64'hDD);
    #1;
    chk("t5_cv", commit_valid_o, 2'b01);
    chk("t5_ready_full", dec_ready_o, 0);
    cyc();
    commit_ack_i = '0;
    disp(1'b0, 5'd0, 5'd0, 64'd0);
    #1;
    chk("t5_ready_after", dec_ready_o, 1);
    chk("t5_full_after", full_o, 0);
    chk("t5_count", dut.count_q, 7);
    chk("t5_tail", dut.tail_q, 4);
    cyc();

    // flush with pending writeback and ack
    wb_valid_i = 4'b0001; wb_trans_id_i = 12'd5;
    #1; cyc();
    wb_trans_id_i = 12'd6; commit_ack_i = 2'b01; flush_i = 1'b1;
    #1; chk("t7_cv_flush", commit_valid_o, 0); chk("t7_iv_flush", issue_valid_o, 0); cyc();
    wb_valid_i = '0; commit_ack_i = '0; flush_i = 1'b0;
    #1;
    chk("t7_count", dut.count_q, 0);
    chk("t7_ptrs", {dut.head_q, dut.iss_q, dut.tail_q}, 0);
    chk("t7_cv", commit_valid_o, 0);
    chk("t7_ready", dec_ready_o, 1);
    chk("t7_full", full_o, 0);
    chk("t7_iv", issue_valid_o, 0);
    cyc();

    // 3 issued + 2 unissued, then flush the unissued ones
    for (int i = 0; i < 5; i++) begin
      disp(1'b1, 5'(10 + i), 5'd0, 64'hE0 + 64'(i));
      if (i == 4) issue_ready_i = 1'b0;
      #1; cyc();
    end
    disp(1'b0, 5'd0, 5'd0, 64'd0);
    flush_unissued_i = 1'b1;
    #1; cyc();
    flush_unissued_i = 1'b0;
    #1;
    chk("t6_count", dut.count_q, 3);
    chk("t6_tail", dut.tail_q, 3);
    chk("t6_iss", dut.iss_q, 3);
    chk("t6_iv", issue_valid_o, 0);
    disp(1'b1, 5'd20, 5'd0, 64'hF0);
    issue_ready_i = 1'b1;
    cyc();
    disp(1'b0, 5'd0, 5'd0, 64'd0);
    #1; chk("t6_reiss", issue_valid_o, 1); chk("t6_reid", issue_trans_id_o, 3);
    chk("t6_repl", issue_payload_o, 64'hF0);
    cyc();

    // asynchronous reset mid-cycle
    rst_ni = 1'b0;
    #1;
    chk("ar_count", dut.count_q, 0);
    chk("ar_ready", dec_ready_o, 1);
    chk("ar_iv", issue_valid_o, 0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
